// File: rtl/uart_report_scheduler_if.sv
// uart_report_scheduler_if: requester handshakes and UART buffer signals of the report scheduler
interface uart_report_scheduler_if #(parameter int N = 48);
  logic         en_16_x_baud, buffer_full, req0, req1, ack0, ack1, write_buffer, busy, grant_id;
  logic [N-1:0] data0, data1;
  logic [7:0]   ascii_out;
  modport master (
    output en_16_x_baud, buffer_full, req0, data0, req1, data1,
    input  ack0, ack1, ascii_out, write_buffer, busy, grant_id
  );
  modport slave (
    input  en_16_x_baud, buffer_full, req0, data0, req1, data1,
    output ack0, ack1, ascii_out, write_buffer, busy, grant_id
  );
endinterface

// File: rtl/uart_report_scheduler.sv
// uart_report_scheduler: round-robin picks one of two N-bit words and streams it as ASCII '0'/'1' then CR LF
module uart_report_scheduler #(parameter int N = 48) (
  input logic clk,
  input logic rst_n,
  uart_report_scheduler_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, SEND_BITS, SEND_CR, SEND_LF} state_t;
  state_t        r_state;
  logic [N-1:0]  r_shift;
  logic [CW-1:0] r_cnt;
  logic          r_grant, r_last, r_ack0, r_ack1;
  logic          w_req, w_pick, w_wr;
  assign w_req  = bus.req0 | bus.req1;
  // on a tie the requester not served last wins; r_last resets to 1 so requester 0 wins first
  assign w_pick = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
  assign w_wr   = (r_state != IDLE) & bus.en_16_x_baud & ~bus.buffer_full;
  always_comb
    bus.ascii_out = r_state == SEND_BITS ? (r_shift[N-1] ? 8'd49 : 8'd48) :
                    r_state == SEND_CR   ? 8'd13 :
                    r_state == SEND_LF   ? 8'd10 : 8'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: if (w_req) begin
          r_grant <= w_pick;
          r_shift <= w_pick ? bus.data1 : bus.data0;
          r_cnt   <= '0;
          r_ack0  <= ~w_pick;
          r_ack1  <= w_pick;
          r_state <= SEND_BITS;
        end
        SEND_BITS: if (w_wr) begin
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= SEND_CR;
        end
        SEND_CR: if (w_wr) r_state <= SEND_LF;
        SEND_LF: if (w_wr) begin
          r_last  <= r_grant;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.write_buffer = w_wr;
  assign bus.busy         = r_state != IDLE;
  assign bus.grant_id     = r_grant;
  assign bus.ack0         = r_ack0;
  assign bus.ack1         = r_ack1;
endmodule

// File: tb/tb_uart_report_scheduler.sv
// tb_uart_report_scheduler: directed scenarios with hand-computed character streams, N=4
module tb_uart_report_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int vec = 0, err = 0;
  int cyc = 0, wn = 0, ack0_n = 0, ack1_n = 0;
  int wc[16];
  logic [95:0] wlog = '0;

  uart_report_scheduler_if #(.N(4)) bus ();
  uart_report_scheduler #(.N(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  // write/ack log taken mid-cycle, away from the rising edge
  always @(negedge clk) begin
    cyc++;
    if (bus.write_buffer) begin
      wlog = {wlog[87:0], bus.ascii_out};
      if (wn < 16) wc[wn] = cyc;
      wn++;
    end
    if (bus.ack0) ack0_n++;
    if (bus.ack1) ack1_n++;
  end

  task automatic clear_log();
    wn = 0; wlog = '0; ack0_n = 0; ack1_n = 0;
  endtask

  task automatic run(input int n, input bit pace);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
      if (pace) bus.en_16_x_baud = (k % 16 == 15);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.req0 = 1'b1; bus.data0 = 4'hF; bus.en_16_x_baud = 1'b1;
    #3;
    vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vec++; if (bus.write_buffer !== 1'b0) begin err++; $display("FAIL reset_write: got %b want 0", bus.write_buffer); end
    vec++; if (bus.ascii_out !== 8'd0) begin err++; $display("FAIL reset_ascii: got %0d want 0", bus.ascii_out); end
    vec++; if (bus.grant_id !== 1'b0) begin err++; $display("FAIL reset_grant: got %b want 0", bus.grant_id); end
    @(posedge clk); #1;
    vec++; if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000) begin err++; $display("FAIL reset_hold: got ack0/ack1/busy %b want 000", {bus.ack0, bus.ack1, bus.busy}); end
    bus.req0 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    clear_log();
    bus.data0 = 4'b1011; bus.req0 = 1'b1;
    run(10, 1'b0);
    vec++; if (wn !== 6) begin err++; $display("FAIL single_count: got %0d want 6", wn); end
    vec++; if (wlog[47:0] !== {8'd49, 8'd48, 8'd49, 8'd49, 8'd13, 8'd10}) begin err++; $display("FAIL single_chars: got %h want 313031310d0a", wlog[47:0]); end
    vec++; if (wc[5] - wc[0] !== 5) begin err++; $display("FAIL single_consecutive: got span %0d want 5", wc[5] - wc[0]); end
    vec++; if (ack0_n !== 1 || ack1_n !== 0) begin err++; $display("FAIL single_acks: got ack0 %0d ack1 %0d want 1 0", ack0_n, ack1_n); end
    vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL single_idle: got busy %b want 0", bus.busy); end
  endtask

  task automatic test_tie();
    rst_n = 1'b0;
    clear_log();
    bus.data0 = 4'b0001; bus.data1 = 4'b1000; bus.req0 = 1'b1; bus.req1 = 1'b1;
    #2 rst_n = 1'b1;
    run(3, 1'b0);
    vec++; if (bus.grant_id !== 1'b0) begin err++; $display("FAIL tie_first_grant: got %b want 0", bus.grant_id); end
    vec++; if (ack1_n !== 0) begin err++; $display("FAIL tie_busy_ignore: got ack1 %0d want 0", ack1_n); end
    run(6, 1'b0);
    vec++; if (bus.grant_id !== 1'b1) begin err++; $display("FAIL tie_second_grant: got %b want 1", bus.grant_id); end
    run(10, 1'b0);
    vec++; if (wn !== 12) begin err++; $display("FAIL tie_count: got %0d want 12", wn); end
    vec++; if (wlog !== {8'd48, 8'd48, 8'd48, 8'd49, 8'd13, 8'd10, 8'd49, 8'd48, 8'd48, 8'd48, 8'd13, 8'd10}) begin err++; $display("FAIL tie_chars: got %h want 3030303 10d0a313030300d0a", wlog); end
    vec++; if (wc[6] - wc[5] !== 2) begin err++; $display("FAIL tie_idle_gap: got %0d want 2", wc[6] - wc[5]); end
    vec++; if (ack0_n !== 1 || ack1_n !== 1) begin err++; $display("FAIL tie_acks: got ack0 %0d ack1 %0d want 1 1", ack0_n, ack1_n); end
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    run(1, 1'b0);
    vec++; if (bus.grant_id !== 1'b0 || bus.busy !== 1'b1) begin err++; $display("FAIL tie_third_grant: got grant %b busy %b want 0 1", bus.grant_id, bus.busy); end
    run(20, 1'b0);
    vec++; if (ack0_n !== 2 || ack1_n !== 2) begin err++; $display("FAIL tie_third_acks: got ack0 %0d ack1 %0d want 2 2", ack0_n, ack1_n); end
  endtask

  task automatic test_full();
    clear_log();
    bus.data0 = 4'b1001; bus.req0 = 1'b1;
    run(3, 1'b0);
    bus.buffer_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++; if (bus.write_buffer !== 1'b0 || bus.ascii_out !== 8'd48) begin err++; $display("FAIL full_stall%0d: got write %b ascii %0d want 0 48", i, bus.write_buffer, bus.ascii_out); end
      @(posedge clk); #1;
    end
    bus.buffer_full = 1'b0;
    run(10, 1'b0);
    vec++; if (wn !== 6) begin err++; $display("FAIL full_count: got %0d want 6", wn); end
    vec++; if (wlog[47:0] !== {8'd49, 8'd48, 8'd48, 8'd49, 8'd13, 8'd10}) begin err++; $display("FAIL full_chars: got %h want 313030310d0a", wlog[47:0]); end
    vec++; if (wc[2] - wc[1] !== 6) begin err++; $display("FAIL full_gap: got %0d want 6", wc[2] - wc[1]); end
  endtask

  task automatic test_pace();
    clear_log();
    bus.en_16_x_baud = 1'b0; bus.data0 = 4'b1011; bus.req0 = 1'b1;
    run(120, 1'b1);
    vec++; if (wn !== 6) begin err++; $display("FAIL pace_count: got %0d want 6", wn); end
    vec++; if (wlog[47:0] !== {8'd49, 8'd48, 8'd49, 8'd49, 8'd13, 8'd10}) begin err++; $display("FAIL pace_chars: got %h want 313031310d0a", wlog[47:0]); end
    for (int i = 1; i < 6; i++) begin
      vec++; if (wc[i] - wc[i-1] !== 16) begin err++; $display("FAIL pace_spacing%0d: got %0d want 16", i, wc[i] - wc[i-1]); end
    end
    vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL pace_idle: got busy %b want 0", bus.busy); end
    bus.en_16_x_baud = 1'b1;
  endtask

  task automatic test_reset_mid();
    clear_log();
    bus.data0 = 4'b1011; bus.req0 = 1'b1;
    run(4, 1'b0);
    rst_n = 1'b0;
    #1;
    vec++; if ({bus.busy, bus.write_buffer, bus.grant_id} !== 3'b000) begin err++; $display("FAIL rstmid_ctl: got busy/write/grant %b want 000", {bus.busy, bus.write_buffer, bus.grant_id}); end
    vec++; if (bus.ascii_out !== 8'd0) begin err++; $display("FAIL rstmid_ascii: got %0d want 0", bus.ascii_out); end
    run(3, 1'b0);
    rst_n = 1'b1;
    run(3, 1'b0);
    vec++; if (wn !== 3) begin err++; $display("FAIL rstmid_abort: got %0d writes want 3", wn); end
    vec++; if (ack0_n !== 1) begin err++; $display("FAIL rstmid_noreack: got %0d acks want 1", ack0_n); end
    clear_log();
    bus.req0 = 1'b1;
    run(10, 1'b0);
    vec++; if (wn !== 6) begin err++; $display("FAIL rstmid_count: got %0d want 6", wn); end
    vec++; if (wlog[47:0] !== {8'd49, 8'd48, 8'd49, 8'd49, 8'd13, 8'd10}) begin err++; $display("FAIL rstmid_chars: got %h want 313031310d0a", wlog[47:0]); end
  endtask

  initial begin
    bus.en_16_x_baud = 1'b1; bus.buffer_full = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0;
    test_reset();
    test_single();
    test_tie();
    test_full();
    test_pace();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
